rs_syndrome_unit: RTL and testbench



---
 rtl/rs_pkg.sv | 40 ++++
 rtl/rs_synd_cell.sv | 33 +++
 rtl/rs_syndrome_unit.sv | 141 ++++++++++++++
 tb/tb_rs_syndrome_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared RS(544,514) over GF(2^10) definitions for the encoder and decoder stages.
// The GF helpers are meant for elaboration-time constants, so each use folds into an XOR network.
package rs_pkg;

  localparam int K    = 514;
  localparam int N    = 544;
  localparam int NSYM = N - K;
  localparam int SW   = 10;

  // x^10 + x^3 + 1
  localparam logic [SW:0]   PRIM_POLY = 11'h409;
  localparam logic [SW-1:0] PRIM_TAPS = PRIM_POLY[SW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [SW-1:0] gf_mul_const(input logic [SW-1:0] a,
                                                 input logic [SW-1:0] c);
    logic [SW-1:0] acc;
    logic [SW-1:0] sh;
    acc = '0;
    sh  = a;
    for (int b = 0; b < SW; b++) begin
      if (c[b]) acc = acc ^ sh;
      sh = {sh[SW-2:0], 1'b0} ^ (sh[SW-1] ? PRIM_TAPS : '0);
    end
    return acc;
  endfunction

  function automatic logic [SW-1:0] gf_alpha_pow(input int e);
    logic [SW-1:0] p;
    p = {{(SW-1){1'b0}}, 1'b1};
    for (int j = 0; j < e; j++) p = gf_mul_const(p, {{(SW-2){1'b0}}, 2'b10});
    return p;
  endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// One syndrome accumulator S_i = r(alpha^ROOT_EXP), evaluated by Horner's rule.
// load restarts the sum with the first symbol; step folds in the next symbol.
module rs_synd_cell
  import rs_pkg::*;
#(
  parameter int ROOT_EXP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [SW-1:0] data_in,
  output logic [SW-1:0] synd_d,
  output logic [SW-1:0] synd_q
);

  localparam logic [SW-1:0] ROOT = gf_alpha_pow(ROOT_EXP);

  always_comb begin
    synd_d = synd_q;
    if (load) begin
      synd_d = data_in;
    end else if (step) begin
      synd_d = gf_mul_const(synd_q, ROOT) ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) synd_q <= '0;
    else        synd_q <= synd_d;
  end

endmodule

// File: rtl/rs_syndrome_unit.sv
// RS(544,514) receive front end: forwards message symbols, drops parity, computes 30 syndromes.
//   state | meaning
//   IDLE  | waiting for an accepted sop
//   RECV  | accumulating symbols 1..543 of a codeword
//   DONE  | syndromes final, synd_valid high, input stalled for one cycle
module rs_syndrome_unit
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sop,
  input  logic               valid_in,
  input  logic [SW-1:0]      data_in,
  output logic               ready,
  output logic               msg_valid,
  output logic [SW-1:0]      msg_data,
  output logic               msg_sop,
  output logic               msg_eop,
  output logic               synd_valid,
  output logic [NSYM*SW-1:0] syndromes,
  output logic               err_detected,
  output logic               pkt_abort
);

  localparam logic [9:0] LAST_IDX     = 10'(N - 1);
  localparam logic [9:0] MSG_LAST_IDX = 10'(K - 1);
  localparam logic [9:0] K_IDX        = 10'(K);

  state_e             state_q, state_d;
  logic [9:0]         count_q, count_d;
  logic               msg_valid_q, msg_valid_d;
  logic [SW-1:0]      msg_data_q, msg_data_d;
  logic               msg_sop_q, msg_sop_d;
  logic               msg_eop_q, msg_eop_d;
  logic               synd_valid_q, synd_valid_d;
  logic               err_q, err_d;
  logic               pkt_abort_q, pkt_abort_d;

  logic               accept;
  logic               start;
  logic               step;
  logic               in_pkt;
  logic               last;
  logic [9:0]         cur_idx;
  logic [NSYM*SW-1:0] synd_nxt;

  assign ready  = (state_q != DONE);
  assign accept = valid_in && ready;
  // A sop is honoured in IDLE and in RECV; in RECV it restarts the codeword.
  assign start  = accept && sop;
  assign step   = accept && !sop && (state_q == RECV);
  assign in_pkt = start || step;
  assign last   = step && (count_q == LAST_IDX);
  assign cur_idx = start ? '0 : count_q;

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_cell
    rs_synd_cell #(.ROOT_EXP(gi)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (start),
      .step    (step),
      .data_in (data_in),
      .synd_d  (synd_nxt[gi*SW +: SW]),
      .synd_q  (syndromes[gi*SW +: SW])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          count_d = 10'd1;
        end
      end
      RECV: begin
        if (start) begin
          count_d = 10'd1;
        end else if (last) begin
          state_d = DONE;
          count_d = '0;
        end else if (step) begin
          count_d = count_q + 10'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    msg_valid_d  = in_pkt && (cur_idx < K_IDX);
    msg_sop_d    = in_pkt && (cur_idx == '0);
    msg_eop_d    = in_pkt && (cur_idx == MSG_LAST_IDX);
    msg_data_d   = msg_valid_d ? data_in : msg_data_q;
    synd_valid_d = last;
    pkt_abort_d  = start && (state_q == RECV);
    err_d        = err_q;
    // err_detected must be valid alongside synd_valid, so reduce the next-state syndromes.
    if (last)       err_d = |synd_nxt;
    else if (start) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      msg_valid_q  <= 1'b0;
      msg_data_q   <= '0;
      msg_sop_q    <= 1'b0;
      msg_eop_q    <= 1'b0;
      synd_valid_q <= 1'b0;
      err_q        <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      msg_valid_q  <= msg_valid_d;
      msg_data_q   <= msg_data_d;
      msg_sop_q    <= msg_sop_d;
      msg_eop_q    <= msg_eop_d;
      synd_valid_q <= synd_valid_d;
      err_q        <= err_d;
      pkt_abort_q  <= pkt_abort_d;
    end
  end

  assign msg_valid    = msg_valid_q;
  assign msg_data     = msg_data_q;
  assign msg_sop      = msg_sop_q;
  assign msg_eop      = msg_eop_q;
  assign synd_valid   = synd_valid_q;
  assign err_detected = err_q;
  assign pkt_abort    = pkt_abort_q;

endmodule

// File: tb/tb_rs_syndrome_unit.sv
// Directed bench for rs_syndrome_unit with its own GF(2^10) encoder and syndrome model.
module tb_rs_syndrome_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sop;
  logic         valid_in;
  logic [9:0]   data_in;
  logic         ready;
  logic         msg_valid;
  logic [9:0]   msg_data;
  logic         msg_sop;
  logic         msg_eop;
  logic         synd_valid;
  logic [299:0] syndromes;
  logic         err_detected;
  logic         pkt_abort;

  always #5 clk = ~clk;

  rs_syndrome_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sop          (sop),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready        (ready),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .msg_sop      (msg_sop),
    .msg_eop      (msg_eop),
    .synd_valid   (synd_valid),
    .syndromes    (syndromes),
    .err_detected (err_detected),
    .pkt_abort    (pkt_abort)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] cw  [544];
  logic [9:0] msg [514];
  logic [9:0] gen [31];

  logic [9:0] got_msg [$];
  int   n_sop, n_eop, n_sv, n_abort, eop_pos;
  logic sv_at_last, err_at_last, rdy_at_last;

  function automatic logic [9:0] xt(input logic [9:0] a);
    return a[9] ? ({a[8:0], 1'b0} ^ 10'h009) : {a[8:0], 1'b0};
  endfunction

  function automatic logic [9:0] tb_mul(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 10; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [9:0] tb_apow(input int e);
    logic [9:0] p;
    int ee;
    ee = e % 1023;
    p = 10'h001;
    for (int i = 0; i < ee; i++) p = xt(p);
    return p;
  endfunction

  function automatic logic [299:0] model_synd();
    logic [299:0] v;
    logic [9:0]   s, a;
    v = '0;
    for (int i = 0; i < 30; i++) begin
      a = tb_apow(i);
      s = '0;
      for (int j = 0; j < 544; j++) s = tb_mul(s, a) ^ cw[j];
      v[i*10 +: 10] = s;
    end
    return v;
  endfunction

  task automatic build_gen();
    logic [9:0] a;
    for (int j = 0; j < 31; j++) gen[j] = '0;
    gen[0] = 10'h001;
    for (int i = 0; i < 30; i++) begin
      a = tb_apow(i);
      for (int j = i + 1; j > 0; j--) gen[j] = gen[j-1] ^ tb_mul(gen[j], a);
      gen[0] = tb_mul(gen[0], a);
    end
  endtask

  task automatic random_msg_encode();
    logic [9:0] p [30];
    logic [9:0] fb;
    for (int m = 0; m < 514; m++) msg[m] = 10'($urandom_range(1023));
    for (int j = 0; j < 30; j++) p[j] = '0;
    for (int m = 0; m < 514; m++) begin
      fb = msg[m] ^ p[29];
      for (int j = 29; j > 0; j--) p[j] = p[j-1] ^ tb_mul(fb, gen[j]);
      p[0] = tb_mul(fb, gen[0]);
      cw[m] = msg[m];
    end
    for (int j = 0; j < 30; j++) cw[514+j] = p[29-j];
  endtask

  task automatic zero_cw();
    for (int j = 0; j < 544; j++) cw[j] = '0;
  endtask

  task automatic clear_mon();
    got_msg.delete();
    n_sop = 0; n_eop = 0; n_sv = 0; n_abort = 0; eop_pos = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (msg_valid) begin
      if (msg_sop) begin
        n_sop++;
        got_msg.delete();
      end
      if (msg_eop) begin
        n_eop++;
        eop_pos = got_msg.size();
      end
      got_msg.push_back(msg_data);
    end
    if (synd_valid) n_sv++;
    if (pkt_abort)  n_abort++;
  endtask

  task automatic send_cw(input int nsym, input int gap_pct);
    int g, w;
    for (int i = 0; i < nsym; i++) begin
      g = 0;
      while (gap_pct > 0 && g < 10 && $urandom_range(99) < gap_pct) begin
        valid_in = 1'b0;
        sop      = 1'b0;
        data_in  = 10'($urandom_range(1023));
        tick();
        g++;
      end
      w = 0;
      while (!ready && w < 4) begin
        valid_in = 1'b0;
        tick();
        w++;
      end
      checks++;
      if (!ready) begin
        errors++;
        $display("FAIL ready_timeout: ready=%b required 1 at symbol %0d", ready, i);
      end
      valid_in = 1'b1;
      sop      = (i == 0);
      data_in  = cw[i];
      tick();
    end
    valid_in    = 1'b0;
    sop         = 1'b0;
    sv_at_last  = synd_valid;
    err_at_last = err_detected;
    rdy_at_last = ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sop = 1'b0; valid_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, msg_valid, msg_sop, msg_eop, synd_valid, err_detected, pkt_abort} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 1000000",
               {ready, msg_valid, msg_sop, msg_eop, synd_valid, err_detected, pkt_abort});
    end
    checks++;
    if (syndromes !== 300'd0 || msg_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: syndromes=%h msg_data=%h required 0", syndromes, msg_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_zero();
    zero_cw();
    clear_mon();
    send_cw(544, 0);
    checks++;
    if (sv_at_last !== 1'b1 || rdy_at_last !== 1'b0) begin
      errors++;
      $display("FAIL zero_timing: synd_valid=%b ready=%b required 1 0", sv_at_last, rdy_at_last);
    end
    checks++;
    if (syndromes !== 300'd0 || err_at_last !== 1'b0) begin
      errors++;
      $display("FAIL zero_synd: got %h err=%b required 0 err=0", syndromes, err_at_last);
    end
    tick();
    checks++;
    if (synd_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse_end: synd_valid=%b ready=%b required 0 1", synd_valid, ready);
    end
    checks++;
    if (got_msg.size() != 514 || n_sop != 1 || n_eop != 1 || eop_pos != 513 || n_sv != 1) begin
      errors++;
      $display("FAIL zero_msg: msgs=%0d sops=%0d eops=%0d eop_pos=%0d svs=%0d required 514 1 1 513 1",
               got_msg.size(), n_sop, n_eop, eop_pos, n_sv);
    end
  endtask

  task automatic test_encoder();
    int bad;
    random_msg_encode();
    clear_mon();
    send_cw(544, 0);
    checks++;
    if (syndromes !== 300'd0 || err_at_last !== 1'b0 || sv_at_last !== 1'b1) begin
      errors++;
      $display("FAIL enc_synd: got %h err=%b sv=%b required 0 err=0 sv=1", syndromes, err_at_last, sv_at_last);
    end
    tick();
    bad = 0;
    for (int m = 0; m < 514; m++) if (m >= got_msg.size() || got_msg[m] !== msg[m]) bad++;
    checks++;
    if (bad != 0 || got_msg.size() != 514) begin
      errors++;
      $display("FAIL enc_msg: %0d wrong of %0d received, required 0 wrong of 514", bad, got_msg.size());
    end
  endtask

  task automatic test_single_last();
    logic [299:0] exp_v;
    exp_v = {30{10'h3ff}};
    zero_cw();
    cw[543] = 10'h3ff;
    clear_mon();
    send_cw(544, 0);
    checks++;
    if (syndromes !== exp_v || err_at_last !== 1'b1) begin
      errors++;
      $display("FAIL last_err_synd: got %h err=%b required %h err=1", syndromes, err_at_last, exp_v);
    end
    tick();
  endtask

  task automatic test_single_first_and_hold();
    logic [299:0] exp_v;
    zero_cw();
    cw[0] = 10'h001;
    for (int i = 0; i < 30; i++) exp_v[i*10 +: 10] = tb_apow(543 * i);
    clear_mon();
    send_cw(544, 0);
    checks++;
    if (syndromes !== exp_v || err_at_last !== 1'b1) begin
      errors++;
      $display("FAIL first_err_synd: got %h err=%b required %h err=1", syndromes, err_at_last, exp_v);
    end
    tick();
    repeat (4) tick();
    // accepts without sop in IDLE must be ignored entirely
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; sop = 1'b0; data_in = 10'h155;
      tick();
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (syndromes !== exp_v || err_detected !== 1'b1) begin
      errors++;
      $display("FAIL hold_synd: got %h err=%b required %h err=1", syndromes, err_detected, exp_v);
    end
    checks++;
    if (got_msg.size() != 0 || n_sv != 0) begin
      errors++;
      $display("FAIL hold_quiet: msgs=%0d svs=%0d required 0 0", got_msg.size(), n_sv);
    end
  endtask

  task automatic test_gaps();
    logic [299:0] exp_v;
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      random_msg_encode();
      if (pass == 1) begin
        cw[100] = cw[100] ^ 10'h2a5;
        cw[530] = cw[530] ^ 10'h001;
      end
      exp_v = model_synd();
      clear_mon();
      send_cw(544, 30);
      checks++;
      if (syndromes !== exp_v || err_at_last !== (pass == 1) || sv_at_last !== 1'b1) begin
        errors++;
        $display("FAIL gap_synd%0d: got %h err=%b sv=%b required %h err=%b sv=1",
                 pass, syndromes, err_at_last, sv_at_last, exp_v, pass == 1);
      end
      tick();
      bad = 0;
      for (int m = 0; m < 514; m++) if (m >= got_msg.size() || got_msg[m] !== cw[m]) bad++;
      checks++;
      if (bad != 0 || got_msg.size() != 514 || n_sv != 1 || eop_pos != 513) begin
        errors++;
        $display("FAIL gap_msg%0d: %0d wrong of %0d, svs=%0d eop_pos=%0d required 0 of 514 1 513",
                 pass, bad, got_msg.size(), n_sv, eop_pos);
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    zero_cw();
    cw[5] = 10'h0f0;
    clear_mon();
    send_cw(200, 0);
    random_msg_encode();
    send_cw(544, 0);
    checks++;
    if (syndromes !== 300'd0 || err_at_last !== 1'b0) begin
      errors++;
      $display("FAIL abort_synd: got %h err=%b required 0 err=0", syndromes, err_at_last);
    end
    tick();
    repeat (2) tick();
    checks++;
    if (n_abort != 1 || n_sv != 1 || n_sop != 2 || n_eop != 1) begin
      errors++;
      $display("FAIL abort_pulses: aborts=%0d svs=%0d sops=%0d eops=%0d required 1 1 2 1",
               n_abort, n_sv, n_sop, n_eop);
    end
    bad = 0;
    for (int m = 0; m < 514; m++) if (m >= got_msg.size() || got_msg[m] !== msg[m]) bad++;
    checks++;
    if (bad != 0 || got_msg.size() != 514) begin
      errors++;
      $display("FAIL abort_msg: %0d wrong of %0d, required 0 of 514", bad, got_msg.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [299:0] exp_v;
    for (int j = 0; j < 544; j++) cw[j] = 10'($urandom_range(1023));
    clear_mon();
    send_cw(300, 0);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ready, msg_valid, msg_sop, msg_eop, synd_valid, err_detected, pkt_abort} !== 7'b1000000
        || syndromes !== 300'd0) begin
      errors++;
      $display("FAIL midreset: ctrl=%b synd=%h required 1000000 and 0",
               {ready, msg_valid, msg_sop, msg_eop, synd_valid, err_detected, pkt_abort}, syndromes);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    random_msg_encode();
    cw[10] = cw[10] ^ 10'h3c1;
    exp_v = model_synd();
    clear_mon();
    send_cw(544, 0);
    checks++;
    if (syndromes !== exp_v || err_at_last !== 1'b1 || sv_at_last !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_synd: got %h err=%b sv=%b required %h err=1 sv=1",
               syndromes, err_at_last, sv_at_last, exp_v);
    end
    tick();
    checks++;
    if (n_abort != 0 || n_sv != 1 || got_msg.size() != 514) begin
      errors++;
      $display("FAIL after_reset_pulses: aborts=%0d svs=%0d msgs=%0d required 0 1 514",
               n_abort, n_sv, got_msg.size());
    end
  endtask

  initial begin
    build_gen();
    test_reset();
    test_all_zero();
    test_encoder();
    test_single_last();
    test_single_first_and_hold();
    test_gaps();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
